lock_ctrl_fsm: RTL and testbench

// - Code-entry controller for the digital lock; consumes the slow divided clock level (new_clk) as a time base.
// - Collects keypad digits and compares them against a stored code.
// - Drives the unlock window, the failed-attempt counter, a lockout timer, and code reprogramming while open.

---
 rtl/lock_pkg.sv | 15 +
 rtl/tick_edge.sv | 17 +
 rtl/lock_ctrl_fsm.sv | 148 ++++++++++++++
 tb/tb_lock_ctrl_fsm.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and widths for the keypad lock controller.
// Imported by the tick detector and the lock FSM.
package lock_pkg;
  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    OPEN,
    PROG,
    LOCKOUT
  } state_t;

  localparam int TIME_W = 8;
  localparam int CNT_W  = 3;
  localparam int FAIL_W = 2;
endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector on the slow divided clock level.
// Produces a one-clk-wide tick for each 0->1 transition.
module tick_edge (
  input  logic clk,
  input  logic reset,
  input  logic tick_in,
  output logic tick
);
  logic tick_q;

  always_ff @(posedge clk) begin
    if (reset) tick_q <= 1'b0;
    else       tick_q <= tick_in;
  end

  assign tick = tick_in & ~tick_q;
endmodule

// File: rtl/lock_ctrl_fsm.sv
// Keypad lock controller: digit capture, code check, unlock
// window, failed-attempt lockout and code reprogramming.
module lock_ctrl_fsm
  import lock_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int UNLOCK_TICKS = 5,
  parameter int LOCKOUT_TICKS = 10,
  parameter int MAX_FAILS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_in,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_enter,
  input  logic               key_clear,
  input  logic               prog_req,
  output logic               unlocked,
  output logic               locked_out,
  output logic               prog_mode,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   digit_count,
  output logic [FAIL_W-1:0]  fail_count,
  output logic [TIME_W-1:0]  time_left
);
  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(NUM_DIGITS);
  localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAILS);
  localparam logic [TIME_W-1:0] T_OPEN   = TIME_W'(UNLOCK_TICKS);
  localparam logic [TIME_W-1:0] T_LOCK   = TIME_W'(LOCKOUT_TICKS);

  state_t              state_q, state_n;
  logic [CODE_W-1:0]   entry_q, entry_n;
  logic [CODE_W-1:0]   code_q, code_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [FAIL_W-1:0]   fail_q, fail_n, fail_inc;
  logic [TIME_W-1:0]   time_q, time_n;
  logic                err_q, err_n;
  logic                tick;

  tick_edge u_tick (
    .clk     (clk),
    .reset   (reset),
    .tick_in (tick_in),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTRY;
      entry_q <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      fail_q  <= '0;
      time_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      entry_q <= entry_n;
      code_q  <= code_n;
      cnt_q   <= cnt_n;
      fail_q  <= fail_n;
      time_q  <= time_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    entry_n  = entry_q;
    code_n   = code_q;
    cnt_n    = cnt_q;
    fail_n   = fail_q;
    time_n   = time_q;
    err_n    = 1'b0;
    fail_inc = fail_q + 1'b1;
    unique case (state_q)
      ENTRY, PROG: begin
        if (key_clear) begin
          entry_n = '0;
          cnt_n   = '0;
        end else if (key_enter) begin
          if (state_q == ENTRY) begin
            state_n = CHECK;
          end else begin
            if (cnt_q == FULL) code_n = entry_q;
            else               err_n  = 1'b1;
            state_n = ENTRY;
            entry_n = '0;
            cnt_n   = '0;
          end
        end else if (key_valid && (cnt_q < FULL)) begin
          entry_n = (entry_q << DIGIT_W) | CODE_W'(key_digit);
          cnt_n   = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        entry_n = '0;
        cnt_n   = '0;
        if ((cnt_q == FULL) && (entry_q == code_q)) begin
          fail_n  = '0;
          time_n  = T_OPEN;
          state_n = OPEN;
        end else begin
          err_n = 1'b1;
          if (fail_inc == FAIL_LIM) begin
            fail_n  = '0;
            time_n  = T_LOCK;
            state_n = LOCKOUT;
          end else begin
            fail_n  = fail_inc;
            state_n = ENTRY;
          end
        end
      end
      OPEN, LOCKOUT: begin
        // prog_req wins over a coincident tick; the window is abandoned
        if ((state_q == OPEN) && prog_req) begin
          time_n  = '0;
          entry_n = '0;
          cnt_n   = '0;
          state_n = PROG;
        end else if (tick) begin
          if (time_q <= 8'd1) begin
            time_n  = '0;
            entry_n = '0;
            cnt_n   = '0;
            state_n = ENTRY;
          end else begin
            time_n = time_q - 1'b1;
          end
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  assign unlocked    = (state_q == OPEN);
  assign locked_out  = (state_q == LOCKOUT);
  assign prog_mode   = (state_q == PROG);
  assign err_pulse   = err_q;
  assign digit_count = cnt_q;
  assign fail_count  = fail_q;
  assign time_left   = time_q;
endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// Self-checking bench for lock_ctrl_fsm: vector table, directed
// corner sequences and random traffic against a digit-queue model.
module tb_lock_ctrl_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_enter = 1'b0;
  logic       key_clear = 1'b0;
  logic       prog_req = 1'b0;
  logic       unlocked, locked_out, prog_mode, err_pulse;
  logic [2:0] digit_count;
  logic [1:0] fail_count;
  logic [7:0] time_left;

  int checks = 0;
  int failures = 0;

  lock_ctrl_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .tick_in     (tick_in),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .prog_req    (prog_req),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .prog_mode   (prog_mode),
    .err_pulse   (err_pulse),
    .digit_count (digit_count),
    .fail_count  (fail_count),
    .time_left   (time_left)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=idle entry, 1=open, 2=programming, 3=lockout
  int m_mode, m_fails, m_time;
  int m_code[4];
  int m_digits[$];
  bit m_pending, m_err, m_prev_tick;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit code_match();
    if (m_digits.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_digits[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit tk;
    tk = tick_in && !m_prev_tick;
    m_prev_tick = tick_in;
    m_err = 1'b0;
    if (reset) begin
      m_mode = 0; m_fails = 0; m_time = 0;
      m_pending = 0; m_prev_tick = 0;
      m_code = '{1, 2, 3, 4};
      m_digits.delete();
    end else if (m_pending) begin
      m_pending = 0;
      if (code_match()) begin
        m_mode = 1; m_fails = 0; m_time = 5;
      end else begin
        m_err = 1;
        m_fails++;
        if (m_fails == 3) begin
          m_fails = 0; m_mode = 3; m_time = 10;
        end
      end
      m_digits.delete();
    end else if (m_mode == 0 || m_mode == 2) begin
      if (key_clear) m_digits.delete();
      else if (key_enter) begin
        if (m_mode == 0) m_pending = 1;
        else begin
          if (m_digits.size() == 4)
            for (int i = 0; i < 4; i++) m_code[i] = m_digits[i];
          else m_err = 1;
          m_digits.delete();
          m_mode = 0;
        end
      end else if (key_valid && m_digits.size() < 4)
        m_digits.push_back(int'(key_digit));
    end else if (m_mode == 1 && prog_req) begin
      m_mode = 2; m_time = 0;
      m_digits.delete();
    end else if (tk) begin
      m_time--;
      if (m_time == 0) m_mode = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    chk("m_unlocked", 32'(unlocked), 32'(m_mode == 1 && !m_pending));
    chk("m_locked_out", 32'(locked_out), 32'(m_mode == 3));
    chk("m_prog_mode", 32'(prog_mode), 32'(m_mode == 2));
    chk("m_err_pulse", 32'(err_pulse), 32'(m_err));
    chk("m_digit_count", 32'(digit_count), 32'(m_digits.size()));
    chk("m_fail_count", 32'(fail_count), 32'(m_fails));
    chk("m_time_left", 32'(time_left), 32'(m_time));
  endtask

  task automatic key(input int d);
    key_valid = 1'b1;
    key_digit = 4'(d);
    step();
    key_valid = 1'b0;
  endtask

  task automatic keys4(input int a, input int b, input int c, input int d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic enter();
    key_enter = 1'b1;
    step();
    key_enter = 1'b0;
  endtask

  task automatic one_tick();
    tick_in = 1'b0;
    step();
    tick_in = 1'b1;
    step();
  endtask

  typedef struct {
    bit v; int d; bit e; bit c; bit p; bit t;
    int unl; int lo; int pm; int err; int dc; int fc; int tl;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl = '{
      '{1,1,0,0,0,0, 0,0,0,0,1,0,0},
      '{1,2,0,0,0,0, 0,0,0,0,2,0,0},
      '{1,3,0,0,0,0, 0,0,0,0,3,0,0},
      '{1,4,0,0,0,0, 0,0,0,0,4,0,0},
      '{0,0,1,0,0,0, 0,0,0,0,4,0,0},
      '{0,0,0,0,0,1, 1,0,0,0,0,0,5},
      '{1,7,0,0,0,1, 1,0,0,0,0,0,5},
      '{0,0,0,0,0,0, 1,0,0,0,0,0,5},
      '{0,0,0,0,0,1, 1,0,0,0,0,0,4},
      '{0,0,0,0,0,0, 1,0,0,0,0,0,4},
      '{0,0,0,0,0,1, 1,0,0,0,0,0,3},
      '{0,0,0,0,0,0, 1,0,0,0,0,0,3},
      '{0,0,0,0,0,1, 1,0,0,0,0,0,2},
      '{0,0,0,0,0,0, 1,0,0,0,0,0,2},
      '{0,0,0,0,0,1, 1,0,0,0,0,0,1},
      '{0,0,0,0,0,0, 1,0,0,0,0,0,1},
      '{0,0,0,0,0,1, 0,0,0,0,0,0,0}
    };

    step();
    step();
    chk("rst_unlocked", 32'(unlocked), 0);
    chk("rst_locked_out", 32'(locked_out), 0);
    chk("rst_prog_mode", 32'(prog_mode), 0);
    chk("rst_err", 32'(err_pulse), 0);
    chk("rst_count", 32'(digit_count), 0);
    chk("rst_time", 32'(time_left), 0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      key_valid = tbl[i].v;
      key_digit = 4'(tbl[i].d);
      key_enter = tbl[i].e;
      key_clear = tbl[i].c;
      prog_req  = tbl[i].p;
      tick_in   = tbl[i].t;
      step();
      chk($sformatf("vec%0d_unlocked", i), 32'(unlocked), tbl[i].unl);
      chk($sformatf("vec%0d_locked", i), 32'(locked_out), tbl[i].lo);
      chk($sformatf("vec%0d_prog", i), 32'(prog_mode), tbl[i].pm);
      chk($sformatf("vec%0d_err", i), 32'(err_pulse), tbl[i].err);
      chk($sformatf("vec%0d_count", i), 32'(digit_count), tbl[i].dc);
      chk($sformatf("vec%0d_fails", i), 32'(fail_count), tbl[i].fc);
      chk($sformatf("vec%0d_time", i), 32'(time_left), tbl[i].tl);
    end
    key_valid = 0; key_enter = 0; key_clear = 0; prog_req = 0;

    // three wrong codes -> lockout
    for (int k = 1; k <= 3; k++) begin
      keys4(9, 9, 9, 9);
      enter();
      step();
      chk("wrong_err", 32'(err_pulse), 1);
      if (k < 3) begin
        chk("wrong_fails", 32'(fail_count), 32'(k));
      end else begin
        chk("lock_on", 32'(locked_out), 1);
        chk("lock_time", 32'(time_left), 10);
        chk("lock_fails", 32'(fail_count), 0);
      end
    end
    keys4(1, 2, 3, 4);
    enter();
    step();
    chk("lock_keys_ignored", 32'(digit_count), 0);
    chk("lock_still", 32'(locked_out), 1);
    chk("lock_no_err", 32'(err_pulse), 0);
    for (int i = 0; i < 9; i++) one_tick();
    chk("lock_t1", 32'(time_left), 1);
    chk("lock_t1_on", 32'(locked_out), 1);
    one_tick();
    chk("lock_off", 32'(locked_out), 0);

    // short entry fails, over-long entry drops the fifth digit
    key(1); key(2); key(3);
    enter();
    step();
    chk("short_err", 32'(err_pulse), 1);
    chk("short_fails", 32'(fail_count), 1);
    keys4(1, 2, 3, 4);
    key(5);
    chk("long_count", 32'(digit_count), 4);
    enter();
    step();
    chk("long_unlock", 32'(unlocked), 1);
    chk("long_fails", 32'(fail_count), 0);

    // reprogram while open
    prog_req = 1'b1;
    step();
    prog_req = 1'b0;
    chk("prog_on", 32'(prog_mode), 1);
    chk("prog_time", 32'(time_left), 0);
    keys4(5, 6, 7, 8);
    enter();
    chk("prog_done", 32'(prog_mode), 0);
    chk("prog_no_err", 32'(err_pulse), 0);
    keys4(1, 2, 3, 4);
    enter();
    step();
    chk("old_code_err", 32'(err_pulse), 1);
    keys4(5, 6, 7, 8);
    enter();
    step();
    chk("new_code_unlock", 32'(unlocked), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_relock", 32'(unlocked), 0);
    keys4(1, 2, 3, 4);
    enter();
    step();
    chk("default_unlock", 32'(unlocked), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // digit coincident with enter is dropped
    key(1); key(2); key(3);
    key_valid = 1'b1;
    key_digit = 4'd4;
    key_enter = 1'b1;
    step();
    key_valid = 1'b0;
    key_enter = 1'b0;
    chk("coinc_count", 32'(digit_count), 3);
    step();
    chk("coinc_err", 32'(err_pulse), 1);
    chk("coinc_unlocked", 32'(unlocked), 0);

    // clear beats enter
    key(1); key(2);
    key_clear = 1'b1;
    key_enter = 1'b1;
    step();
    key_clear = 1'b0;
    key_enter = 1'b0;
    chk("clr_count", 32'(digit_count), 0);
    step();
    chk("clr_no_err", 32'(err_pulse), 0);
    chk("clr_fails", 32'(fail_count), 1);

    // random traffic against the model
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(499) == 0);
      prog_req  = ($urandom_range(99) < 4);
      key_clear = ($urandom_range(39) == 0);
      key_enter = ($urandom_range(7) == 0);
      key_valid = ($urandom_range(2) == 0);
      if (m_digits.size() < 4 && $urandom_range(4) != 0)
        key_digit = 4'(m_code[m_digits.size()]);
      else
        key_digit = 4'($urandom);
      if ($urandom_range(2) == 0) tick_in = ~tick_in;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
